// File: rtl/stream_gen_chk_pkg.sv
// Shared types and LFSR helpers for the stream generator/checker pair.
// LFSR use is compiled in only when STREAM_GEN_CHK_RAND_EN is defined.
package stream_gen_chk_pkg;
  typedef enum logic [1:0] {GAP, SEND, DONE} gen_state_e;

  // x^16 + x^14 + x^13 + x^11 + 1 -> state bits 15,13,12,10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [15:0] SEED_GEN  = 16'hACE1;
  localparam logic [15:0] SEED_CHK  = 16'h5A3C;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction
endpackage

// File: rtl/stream_throttle.sv
// Loadable down-counter; length is DELAY, or lfsr mod (DELAY+1) when
// STREAM_GEN_CHK_RAND_EN is defined. Decrements while gate is high.
module stream_throttle
  import stream_gen_chk_pkg::*;
#(
  parameter int DELAY = 0
`ifdef STREAM_GEN_CHK_RAND_EN
  , parameter logic [15:0] SEED = 16'h0001
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic gate,
  output logic zero
);
  localparam int CW = (DELAY < 1) ? 1 : $clog2(DELAY + 1);

  logic [CW-1:0] cnt_q, cnt_d, len;

`ifdef STREAM_GEN_CHK_RAND_EN
  localparam logic [CW-1:0] RST_LEN = CW'(32'(SEED) % 32'(DELAY + 1));
  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    len    = CW'(32'(lfsr_q) % 32'(DELAY + 1));
    lfsr_d = load ? lfsr_next(lfsr_q) : lfsr_q;
  end

  // the reset load consumes the seed, so the LFSR starts one step ahead
  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= lfsr_next(SEED);
    else     lfsr_q <= lfsr_d;
  end
`else
  localparam logic [CW-1:0] RST_LEN = CW'(DELAY);
  assign len = CW'(DELAY);
`endif

  always_comb begin
    cnt_d = cnt_q;
    if (load)                     cnt_d = len;
    else if (gate && cnt_q != '0) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= RST_LEN;
    else     cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);
endmodule

// File: rtl/stream_gen_chk.sv
// Valid/ready incrementing-sequence generator plus in-order checker with
// saturating counters. STREAM_GEN_CHK_RAND_EN selects LFSR-random gaps/stalls.
module stream_gen_chk
  import stream_gen_chk_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DELAY_GEN  = 0,
  parameter int                    DELAY_CHK  = 0,
  parameter logic [DATA_WIDTH-1:0] DATA_INIT  = '0,
  parameter int                    NUM_XFER   = 0,
  parameter int                    CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  gen_en,
  output logic                  gen_down_valid,
  output logic [DATA_WIDTH-1:0] gen_down_data,
  input  logic                  gen_down_ready,
  output logic                  gen_done,
  input  logic                  chk_up_valid,
  input  logic [DATA_WIDTH-1:0] chk_up_data,
  output logic                  chk_up_ready,
  output logic [CNT_WIDTH-1:0]  chk_ok_cnt,
  output logic [CNT_WIDTH-1:0]  chk_err_cnt,
  output logic                  chk_err
);
  gen_state_e            state_q, state_d;
  logic                  valid_q, valid_d, done_q, done_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [31:0]           xfer_q, xfer_d;
  logic                  gap_load, gap_zero;

  logic                  ready_q, ready_d, first_q, first_d, stall_zero, fire;
  logic [DATA_WIDTH-1:0] exp_q, exp_d;
  logic [CNT_WIDTH-1:0]  ok_q, ok_d, errc_q, errc_d;
  logic                  err_q, err_d;

  stream_throttle #(
    .DELAY(DELAY_GEN)
`ifdef STREAM_GEN_CHK_RAND_EN
    , .SEED(SEED_GEN)
`endif
  ) u_gap (
    .clk(clk), .rst(rst), .load(gap_load),
    .gate((state_q == GAP) && gen_en), .zero(gap_zero)
  );

  stream_throttle #(
    .DELAY(DELAY_CHK)
`ifdef STREAM_GEN_CHK_RAND_EN
    , .SEED(SEED_CHK)
`endif
  ) u_stall (
    .clk(clk), .rst(rst), .load(fire), .gate(1'b1), .zero(stall_zero)
  );

  always_comb begin
    state_d  = state_q;
    valid_d  = valid_q;
    data_d   = data_q;
    done_d   = done_q;
    xfer_d   = xfer_q;
    gap_load = 1'b0;
    case (state_q)
      GAP: if (gen_en && gap_zero) begin
        state_d = SEND;
        valid_d = 1'b1;
      end
      SEND: if (valid_q && gen_down_ready) begin
        data_d = data_q + 1'b1;
        xfer_d = xfer_q + 32'd1;
        if (NUM_XFER != 0 && xfer_d == 32'(NUM_XFER)) begin
          state_d = DONE;
          valid_d = 1'b0;
          done_d  = 1'b1;
        end else if (!(DELAY_GEN == 0 && gen_en)) begin
          state_d  = GAP;
          valid_d  = 1'b0;
          gap_load = 1'b1;
        end
      end
      default: valid_d = 1'b0;
    endcase
  end

  // first_q forces the ready slot on edge 1 even though the stall counter
  // comes out of reset holding DELAY_CHK
  always_comb begin
    fire    = first_q | stall_zero;
    ready_d = fire;
    first_d = 1'b0;
    exp_d   = exp_q;
    ok_d    = ok_q;
    errc_d  = errc_q;
    err_d   = err_q;
    if (chk_up_valid && ready_q) begin
      exp_d = chk_up_data + 1'b1;
      if (chk_up_data == exp_q) begin
        if (ok_q != '1) ok_d = ok_q + 1'b1;
      end else begin
        err_d = 1'b1;
        if (errc_q != '1) errc_d = errc_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= GAP;
      valid_q <= 1'b0;
      data_q  <= DATA_INIT;
      done_q  <= 1'b0;
      xfer_q  <= '0;
      ready_q <= 1'b0;
      first_q <= 1'b1;
      exp_q   <= DATA_INIT;
      ok_q    <= '0;
      errc_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      done_q  <= done_d;
      xfer_q  <= xfer_d;
      ready_q <= ready_d;
      first_q <= first_d;
      exp_q   <= exp_d;
      ok_q    <= ok_d;
      errc_q  <= errc_d;
      err_q   <= err_d;
    end
  end

  assign gen_down_valid = valid_q;
  assign gen_down_data  = data_q;
  assign gen_done       = done_q;
  assign chk_up_ready   = ready_q;
  assign chk_ok_cnt     = ok_q;
  assign chk_err_cnt    = errc_q;
  assign chk_err        = err_q;
endmodule

// File: tb/tb_stream_gen_chk.sv
// Directed bench for stream_gen_chk: several parameterisations side by side,
// loopback and bench-driven ports, hand-computed expectations.
module tb_stream_gen_chk;
  logic clk = 1'b0, rst = 1'b1, gen_en = 1'b0, gen_en1 = 1'b0;
  int n_chk = 0, n_pass = 0;
  always #5 clk = ~clk;

  // u0: defaults, loopback
  logic g0_v, c0_r, done0, err0;
  logic [31:0] g0_d;
  logic [15:0] ok0, ec0;
  stream_gen_chk u0 (.clk(clk), .rst(rst), .gen_en(gen_en), .gen_down_valid(g0_v),
    .gen_down_data(g0_d), .gen_down_ready(c0_r), .gen_done(done0), .chk_up_valid(g0_v),
    .chk_up_data(g0_d), .chk_up_ready(c0_r), .chk_ok_cnt(ok0), .chk_err_cnt(ec0), .chk_err(err0));

  // u1: all ports bench-driven, 3-bit counters for saturation
  logic g1_v, g1_r = 1'b0, done1, cv1 = 1'b0, cr1, err1;
  logic [7:0] g1_d, cd1 = 8'd0;
  logic [2:0] ok1, ec1;
  stream_gen_chk #(.DATA_WIDTH(8), .DELAY_GEN(2), .CNT_WIDTH(3)) u1 (.clk(clk), .rst(rst),
    .gen_en(gen_en1), .gen_down_valid(g1_v), .gen_down_data(g1_d), .gen_down_ready(g1_r),
    .gen_done(done1), .chk_up_valid(cv1), .chk_up_data(cd1), .chk_up_ready(cr1),
    .chk_ok_cnt(ok1), .chk_err_cnt(ec1), .chk_err(err1));

  // u2: gaps, stalls and a transfer limit, loopback
  logic g2_v, c2_r, done2, err2;
  logic [31:0] g2_d;
  logic [15:0] ok2, ec2;
  stream_gen_chk #(.DELAY_GEN(3), .DELAY_CHK(2), .NUM_XFER(10)) u2 (.clk(clk), .rst(rst),
    .gen_en(gen_en), .gen_down_valid(g2_v), .gen_down_data(g2_d), .gen_down_ready(c2_r),
    .gen_done(done2), .chk_up_valid(g2_v), .chk_up_data(g2_d), .chk_up_ready(c2_r),
    .chk_ok_cnt(ok2), .chk_err_cnt(ec2), .chk_err(err2));

  // u3: 4-bit data starting near the wrap point, loopback
  logic g3_v, c3_r, done3, err3;
  logic [3:0] g3_d;
  logic [15:0] ok3, ec3;
  stream_gen_chk #(.DATA_WIDTH(4), .DATA_INIT(4'd14)) u3 (.clk(clk), .rst(rst),
    .gen_en(gen_en), .gen_down_valid(g3_v), .gen_down_data(g3_d), .gen_down_ready(c3_r),
    .gen_done(done3), .chk_up_valid(g3_v), .chk_up_data(g3_d), .chk_up_ready(c3_r),
    .chk_ok_cnt(ok3), .chk_err_cnt(ec3), .chk_err(err3));

`ifdef STREAM_GEN_CHK_RAND_EN
  logic g4_v, c4_r, done4, err4;
  logic [31:0] g4_d;
  logic [15:0] ok4, ec4;
  stream_gen_chk #(.DELAY_GEN(7), .DELAY_CHK(7)) u4 (.clk(clk), .rst(rst),
    .gen_en(gen_en), .gen_down_valid(g4_v), .gen_down_data(g4_d), .gen_down_ready(c4_r),
    .gen_done(done4), .chk_up_valid(g4_v), .chk_up_data(g4_d), .chk_up_ready(c4_r),
    .chk_ok_cnt(ok4), .chk_err_cnt(ec4), .chk_err(err4));
`endif

  task automatic do_reset();
    rst = 1'b1; gen_en = 1'b0; gen_en1 = 1'b0; g1_r = 1'b0; cv1 = 1'b0; cd1 = 8'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send_beat(input logic [7:0] v);
    cv1 = 1'b1; cd1 = v;
    @(negedge clk);
    cv1 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; gen_en = 1'b1;
    repeat (2) @(negedge clk);
    n_chk++; if (g0_v !== 1'b0) $display("FAIL reset_valid got %0b want 0", g0_v); else n_pass++;
    n_chk++; if (g0_d !== 32'd0) $display("FAIL reset_data got %0d want 0", g0_d); else n_pass++;
    n_chk++; if (g3_d !== 4'd14) $display("FAIL reset_data_init got %0d want 14", g3_d); else n_pass++;
    n_chk++; if (c0_r !== 1'b0) $display("FAIL reset_ready got %0b want 0", c0_r); else n_pass++;
    n_chk++; if (ok0 !== 16'd0 || ec0 !== 16'd0) $display("FAIL reset_cnts got %0d/%0d want 0/0", ok0, ec0); else n_pass++;
    n_chk++; if (done2 !== 1'b0 || err0 !== 1'b0) $display("FAIL reset_flags got done=%0b err=%0b want 0/0", done2, err0); else n_pass++;
  endtask

  task automatic test_loopback();
    int bad = 0;
    do_reset(); gen_en = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (!(g0_v === 1'b1 && c0_r === 1'b1 && g0_d === 32'(i - 1))) bad++;
    end
    n_chk++; if (bad != 0) $display("FAIL loop_throughput got %0d bad cycles want 0", bad); else n_pass++;
    n_chk++; if (ok0 !== 16'd99) $display("FAIL loop_ok_cnt got %0d want 99", ok0); else n_pass++;
    n_chk++; if (ec0 !== 16'd0 || err0 !== 1'b0) $display("FAIL loop_err got %0d/%0b want 0/0", ec0, err0); else n_pass++;
  endtask

  task automatic test_delays();
    int hs = 0, first_hs = 0, last_hs = -100, bad_stable = 0, bad_space = 0, bad_done = 0, bad_data = 0;
    logic pv = 1'b0, phs = 1'b0;
    logic [31:0] pd = '0;
    do_reset(); gen_en = 1'b1;
    for (int i = 1; i <= 80; i++) begin
      @(negedge clk);
      if (done2 !== (hs == 10)) bad_done++;
      if (pv && !phs && (g2_v !== 1'b1 || g2_d !== pd)) bad_stable++;
      phs = g2_v && c2_r;
      if (phs) begin
        if (hs == 0) first_hs = i + 1;
        if (i + 1 - last_hs < 4) bad_space++;
        if (g2_d !== 32'(hs)) bad_data++;
        last_hs = i + 1;
        hs++;
      end
      pv = g2_v; pd = g2_d;
    end
    n_chk++; if (first_hs != 5) $display("FAIL dly_first_hs got edge %0d want 5", first_hs); else n_pass++;
    n_chk++; if (bad_stable != 0) $display("FAIL dly_stable got %0d bad want 0", bad_stable); else n_pass++;
    n_chk++; if (bad_space != 0) $display("FAIL dly_spacing got %0d bad want 0", bad_space); else n_pass++;
    n_chk++; if (bad_data != 0) $display("FAIL dly_data got %0d bad want 0", bad_data); else n_pass++;
    n_chk++; if (bad_done != 0 || done2 !== 1'b1) $display("FAIL dly_done got %0d bad, done=%0b want 0,1", bad_done, done2); else n_pass++;
    n_chk++; if (ok2 !== 16'd10 || ec2 !== 16'd0) $display("FAIL dly_cnts got %0d/%0d want 10/0", ok2, ec2); else n_pass++;
    n_chk++; if (g2_v !== 1'b0 || hs != 10) $display("FAIL dly_after_done got valid=%0b hs=%0d want 0,10", g2_v, hs); else n_pass++;
  endtask

  task automatic test_wrap();
    logic [3:0] exp_w [4] = '{4'd14, 4'd15, 4'd0, 4'd1};
    do_reset(); gen_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_chk++; if (g3_d !== exp_w[i]) $display("FAIL wrap_data%0d got %0d want %0d", i, g3_d, exp_w[i]); else n_pass++;
    end
    @(negedge clk);
    n_chk++; if (ok3 !== 16'd4 || ec3 !== 16'd0) $display("FAIL wrap_cnts got %0d/%0d want 4/0", ok3, ec3); else n_pass++;
  endtask

  task automatic test_inject();
    logic [7:0] seq [4] = '{8'd0, 8'd1, 8'd5, 8'd6};
    do_reset();
    @(negedge clk);
    n_chk++; if (cr1 !== 1'b1) $display("FAIL inj_ready got %0b want 1", cr1); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      send_beat(seq[k]);
      if (k == 1) begin
        n_chk++; if (err1 !== 1'b0 || ok1 !== 3'd2) $display("FAIL inj_mid got err=%0b ok=%0d want 0,2", err1, ok1); else n_pass++;
      end
    end
    n_chk++; if (ok1 !== 3'd3 || ec1 !== 3'd1) $display("FAIL inj_cnts got %0d/%0d want 3/1", ok1, ec1); else n_pass++;
    n_chk++; if (err1 !== 1'b1) $display("FAIL inj_sticky got %0b want 1", err1); else n_pass++;
    for (int k = 7; k <= 14; k++) send_beat(8'(k));
    n_chk++; if (ok1 !== 3'd7 || ec1 !== 3'd1) $display("FAIL inj_ok_sat got %0d/%0d want 7/1", ok1, ec1); else n_pass++;
    for (int k = 0; k < 10; k++) send_beat(8'(20 + 2 * k));
    n_chk++; if (ec1 !== 3'd7 || ok1 !== 3'd7) $display("FAIL inj_err_sat got %0d/%0d want 7/7", ec1, ok1); else n_pass++;
  endtask

  task automatic test_gen_en();
    do_reset();
    repeat (5) @(negedge clk);
    n_chk++; if (g1_v !== 1'b0) $display("FAIL en_idle got %0b want 0", g1_v); else n_pass++;
    gen_en1 = 1'b1;
    repeat (2) @(negedge clk);
    n_chk++; if (g1_v !== 1'b0) $display("FAIL en_gap got %0b want 0", g1_v); else n_pass++;
    @(negedge clk);
    n_chk++; if (g1_v !== 1'b1 || g1_d !== 8'd0) $display("FAIL en_start got %0b/%0d want 1/0", g1_v, g1_d); else n_pass++;
    gen_en1 = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++; if (g1_v !== 1'b1 || g1_d !== 8'd0) $display("FAIL en_hold got %0b/%0d want 1/0", g1_v, g1_d); else n_pass++;
    g1_r = 1'b1;
    @(negedge clk);
    g1_r = 1'b0;
    n_chk++; if (g1_v !== 1'b0 || g1_d !== 8'd1) $display("FAIL en_hs got %0b/%0d want 0/1", g1_v, g1_d); else n_pass++;
    repeat (4) @(negedge clk);
    gen_en1 = 1'b1;
    repeat (2) @(negedge clk);
    n_chk++; if (g1_v !== 1'b0) $display("FAIL en_freeze got %0b want 0", g1_v); else n_pass++;
    @(negedge clk);
    n_chk++; if (g1_v !== 1'b1 || g1_d !== 8'd1) $display("FAIL en_resume got %0b/%0d want 1/1", g1_v, g1_d); else n_pass++;
  endtask

  task automatic test_rst_mid();
    do_reset(); gen_en = 1'b1;
    repeat (5) @(negedge clk);
    n_chk++; if (g0_d !== 32'd4) $display("FAIL rst_pre got %0d want 4", g0_d); else n_pass++;
    rst = 1'b1;
    @(negedge clk);
    n_chk++; if (g0_v !== 1'b0 || g0_d !== 32'd0) $display("FAIL rst_drop got %0b/%0d want 0/0", g0_v, g0_d); else n_pass++;
    n_chk++; if (ok0 !== 16'd0 || c0_r !== 1'b0) $display("FAIL rst_chk got ok=%0d rdy=%0b want 0/0", ok0, c0_r); else n_pass++;
    rst = 1'b0;
    @(negedge clk);
    n_chk++; if (g0_v !== 1'b1 || g0_d !== 32'd0) $display("FAIL rst_restart got %0b/%0d want 1/0", g0_v, g0_d); else n_pass++;
  endtask

`ifdef STREAM_GEN_CHK_RAND_EN
  task automatic test_rand();
    int hs = 0, run = 0, rmin = 1000, rmax = 0;
    logic seen = 1'b0;
    do_reset(); gen_en = 1'b1;
    for (int i = 1; i <= 1060; i++) begin
      @(negedge clk);
      if (i == 1000) gen_en = 1'b0;
      if (g4_v && c4_r) hs++;
      if (i < 1000) begin
        if (!g4_v) run++;
        else begin
          if (seen && run > 0) begin
            if (run < rmin) rmin = run;
            if (run > rmax) rmax = run;
          end
          if (run > 0) seen = 1'b1;
          run = 0;
        end
      end
    end
    @(negedge clk);
    n_chk++; if (rmax > 8 || rmin < 1) $display("FAIL rand_range got %0d..%0d want within 1..8", rmin, rmax); else n_pass++;
    n_chk++; if (rmin == rmax) $display("FAIL rand_vary got %0d..%0d want distinct", rmin, rmax); else n_pass++;
    n_chk++; if (ec4 !== 16'd0 || ok4 !== 16'(hs)) $display("FAIL rand_cnts got %0d/%0d want %0d/0", ok4, ec4, hs); else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_loopback();
    test_wrap();
    test_inject();
    test_rst_mid();
`ifdef STREAM_GEN_CHK_RAND_EN
    test_rand();
`else
    test_delays();
    test_gen_en();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
